// File: rtl/conv_scheduler.sv
// conv_scheduler
// Central sequencer for the streaming 1-D convolution pipeline. One FSM
// (LOAD -> COMPUTE -> DRAIN -> LOAD) and one set of counters drive the X
// memory write port, the lane/filter read addresses, the per-lane
// accumulator controls, the output buffer writes and the result drain.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   s_valid_x/s_ready_x   input sample handshake (ready only in LOAD)
//   x_wr_en, x_wr_addr    X memory write strobe / address
//   x_rd_base             X read address of lane 0 (lane i reads base+i)
//   f_rd_addr             filter ROM address
//   clr_acc, en_acc       per-lane accumulator clear / accumulate enable
//   y_wr_en, y_wr_addr, y_wr_mask   output buffer group write
//   y_rd_addr             output buffer read address
//   m_valid_y/m_ready_y   result handshake (valid only in DRAIN)
//   busy                  high in COMPUTE or DRAIN
module conv_scheduler #(
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int P     = 2,
    parameter int ADDRX = 3,
    parameter int ADDRF = 2,
    parameter int ADDRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic             x_wr_en,
    output logic [ADDRX-1:0] x_wr_addr,
    output logic [ADDRX-1:0] x_rd_base,
    output logic [ADDRF-1:0] f_rd_addr,
    output logic [P-1:0]     clr_acc,
    output logic [P-1:0]     en_acc,
    output logic             y_wr_en,
    output logic [ADDRY-1:0] y_wr_addr,
    output logic [P-1:0]     y_wr_mask,
    output logic [ADDRY-1:0] y_rd_addr,
    output logic             m_valid_y,
    input  logic             m_ready_y,
    output logic             busy
);

    localparam int SIZE      = LENX - LENF + 1;
    localparam int G         = (SIZE + P - 1) / P;
    localparam int LAST_BASE = G * P;
    localparam int WX        = $clog2(LENX + 1);
    localparam int WF        = $clog2(LENF + 1);
    localparam int WB        = $clog2(LAST_BASE + 1);
    localparam int WY        = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [WX-1:0] wr_cnt;
    logic [WF-1:0] phase;
    logic [WB-1:0] base;      // g*P of the current group; LAST_BASE marks the trailing write cycle
    logic [WY-1:0] rd_cnt;
    logic          primed;

    logic x_hs, y_hs, grp_end, compute_done;

    assign x_hs         = (state == LOAD) && s_valid_x;
    assign y_hs         = (state == DRAIN) && primed && m_ready_y;
    assign grp_end      = (phase == WF'(LENF));
    assign compute_done = (base == WB'(LAST_BASE));

    // Next-state decision: leave LOAD on the last sample, COMPUTE after the
    // trailing group write, DRAIN on the last result handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (x_hs && wr_cnt == WX'(LENX - 1)) state_nxt = COMPUTE;
            COMPUTE: if (compute_done) state_nxt = DRAIN;
            DRAIN:   if (y_hs && rd_cnt == WY'(SIZE - 1)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // State register and all counters. Every counter is returned to zero on
    // the transition out of the state that uses it, so each vector starts
    // from a clean slate. primed lags y_rd_addr by one cycle to cover the
    // buffer read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= LOAD;
            wr_cnt <= '0;
            phase  <= '0;
            base   <= '0;
            rd_cnt <= '0;
            primed <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    if (x_hs) begin
                        wr_cnt <= (wr_cnt == WX'(LENX - 1)) ? '0 : wr_cnt + WX'(1);
                    end
                end
                COMPUTE: begin
                    if (compute_done) begin
                        base  <= '0;
                        phase <= '0;
                    end else if (grp_end) begin
                        phase <= '0;
                        base  <= base + WB'(P);
                    end else begin
                        phase <= phase + WF'(1);
                    end
                end
                DRAIN: begin
                    if (y_hs) begin
                        primed <= 1'b0;
                        rd_cnt <= (rd_cnt == WY'(SIZE - 1)) ? '0 : rd_cnt + WY'(1);
                    end else begin
                        primed <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode. Everything is gated by reset so the outputs drop to
    // zero the moment reset is asserted, without waiting for a clock edge.
    // In COMPUTE the group write for group g-1 lands in phase 0 of group g;
    // the extra cycle with base == LAST_BASE only carries the final write.
    always_comb begin
        s_ready_x = 1'b0;
        x_wr_en   = 1'b0;
        x_wr_addr = '0;
        x_rd_base = '0;
        f_rd_addr = '0;
        clr_acc   = '0;
        en_acc    = '0;
        y_wr_en   = 1'b0;
        y_wr_addr = '0;
        y_wr_mask = '0;
        y_rd_addr = '0;
        m_valid_y = 1'b0;
        busy      = 1'b0;
        if (reset) begin
            case (state)
                LOAD: begin
                    s_ready_x = 1'b1;
                    x_wr_en   = s_valid_x;
                    x_wr_addr = ADDRX'(wr_cnt);
                end
                COMPUTE: begin
                    busy = 1'b1;
                    if (!compute_done) begin
                        if (phase < WF'(LENF)) begin
                            f_rd_addr = ADDRF'(phase);
                            x_rd_base = ADDRX'(int'(base) + int'(phase));
                        end
                        if (phase == '0) begin
                            clr_acc = '1;
                        end else begin
                            for (int i = 0; i < P; i++) begin
                                en_acc[i] = (int'(base) + i) < SIZE;
                            end
                        end
                    end
                    if (phase == '0 && base != '0) begin
                        y_wr_en   = 1'b1;
                        y_wr_addr = ADDRY'(int'(base) - P);
                        for (int i = 0; i < P; i++) begin
                            y_wr_mask[i] = (int'(base) - P + i) < SIZE;
                        end
                    end
                end
                DRAIN: begin
                    busy      = 1'b1;
                    y_rd_addr = ADDRY'(rd_cnt);
                    m_valid_y = primed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler
// Directed bench for conv_scheduler with default parameters (LENX=8,
// LENF=4, P=2 -> SIZE=5, G=3). Inputs change on the falling edge and
// outputs are checked 1 time unit later, away from the rising edge.
module tb_conv_scheduler;

    logic       clk;
    logic       reset;
    logic       s_valid_x;
    logic       s_ready_x;
    logic       x_wr_en;
    logic [2:0] x_wr_addr;
    logic [2:0] x_rd_base;
    logic [1:0] f_rd_addr;
    logic [1:0] clr_acc;
    logic [1:0] en_acc;
    logic       y_wr_en;
    logic [2:0] y_wr_addr;
    logic [1:0] y_wr_mask;
    logic [2:0] y_rd_addr;
    logic       m_valid_y;
    logic       m_ready_y;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Hand-derived COMPUTE schedule, one entry per COMPUTE cycle; -1 = not checked
    int exp_f   [16] = '{0, 1, 2, 3, -1,  0, 1, 2, 3, -1,  0, 1, 2, 3, -1, -1};
    int exp_xb  [16] = '{0, 1, 2, 3, -1,  2, 3, 4, 5, -1,  4, 5, 6, 7, -1, -1};
    int exp_clr [16] = '{3, 0, 0, 0, 0,   3, 0, 0, 0, 0,   3, 0, 0, 0, 0,  -1};
    int exp_en  [16] = '{0, 3, 3, 3, 3,   0, 3, 3, 3, 3,   0, 1, 1, 1, 1,  -1};
    int exp_ywe [16] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0,   1, 0, 0, 0, 0,   1};
    int exp_ywa [16] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   2, 0, 0, 0, 0,   4};
    int exp_ywm [16] = '{0, 0, 0, 0, 0,   3, 0, 0, 0, 0,   3, 0, 0, 0, 0,   1};

    conv_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .x_wr_en   (x_wr_en),
        .x_wr_addr (x_wr_addr),
        .x_rd_base (x_rd_base),
        .f_rd_addr (f_rd_addr),
        .clr_acc   (clr_acc),
        .en_acc    (en_acc),
        .y_wr_en   (y_wr_en),
        .y_wr_addr (y_wr_addr),
        .y_wr_mask (y_wr_mask),
        .y_rd_addr (y_rd_addr),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, drive inputs, settle.
    task automatic apply_stimulus(input logic sv, input logic mr);
        @(negedge clk);
        s_valid_x = sv;
        m_ready_y = mr;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_s_ready_x"}, s_ready_x, 0);
        check_output({tag, "_x_wr_en"},   x_wr_en,   0);
        check_output({tag, "_x_wr_addr"}, x_wr_addr, 0);
        check_output({tag, "_x_rd_base"}, x_rd_base, 0);
        check_output({tag, "_f_rd_addr"}, f_rd_addr, 0);
        check_output({tag, "_clr_acc"},   clr_acc,   0);
        check_output({tag, "_en_acc"},    en_acc,    0);
        check_output({tag, "_y_wr_en"},   y_wr_en,   0);
        check_output({tag, "_y_wr_addr"}, y_wr_addr, 0);
        check_output({tag, "_y_wr_mask"}, y_wr_mask, 0);
        check_output({tag, "_y_rd_addr"}, y_rd_addr, 0);
        check_output({tag, "_m_valid_y"}, m_valid_y, 0);
        check_output({tag, "_busy"},      busy,      0);
    endtask

    // Back-to-back load of 8 samples; returns on COMPUTE cycle 0.
    task automatic load_fast();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0);
            check_output("load_wr_en", x_wr_en, 1);
            check_output("load_wr_addr", x_wr_addr, i);
            check_output("load_ready", s_ready_x, 1);
        end
        apply_stimulus(1'b0, 1'b0);
        check_output("load_done_ready", s_ready_x, 0);
        check_output("load_done_busy", busy, 1);
    endtask

    // Full COMPUTE schedule check starting at cycle 0 (already settled).
    task automatic compute_check();
        for (int c = 0; c < 16; c++) begin
            if (c > 0) apply_stimulus(1'b0, 1'b0);
            check_output("cmp_busy", busy, 1);
            check_output("cmp_ready", s_ready_x, 0);
            if (exp_f[c]   >= 0) check_output("cmp_f_rd_addr", f_rd_addr, exp_f[c]);
            if (exp_xb[c]  >= 0) check_output("cmp_x_rd_base", x_rd_base, exp_xb[c]);
            if (exp_clr[c] >= 0) check_output("cmp_clr_acc", clr_acc, exp_clr[c]);
            if (exp_en[c]  >= 0) check_output("cmp_en_acc", en_acc, exp_en[c]);
            check_output("cmp_y_wr_en", y_wr_en, exp_ywe[c]);
            if (exp_ywe[c] == 1) begin
                check_output("cmp_y_wr_addr", y_wr_addr, exp_ywa[c]);
                check_output("cmp_y_wr_mask", y_wr_mask, exp_ywm[c]);
            end
        end
    endtask

    // One drain cycle: drive m_ready_y and check valid/address.
    task automatic drain_step(input logic mr, input logic ev, input int ea);
        apply_stimulus(1'b0, mr);
        check_output("drain_valid", m_valid_y, ev);
        check_output("drain_rd_addr", y_rd_addr, ea);
        check_output("drain_busy", busy, 1);
        check_output("drain_ready_x", s_ready_x, 0);
    endtask

    task automatic drain_fast();
        for (int n = 0; n < 5; n++) begin
            drain_step(1'b1, 1'b0, n);
            drain_step(1'b1, 1'b1, n);
        end
        apply_stimulus(1'b0, 1'b0);
        check_output("post_drain_ready", s_ready_x, 1);
        check_output("post_drain_busy", busy, 0);
        check_output("post_drain_valid", m_valid_y, 0);
        check_output("post_drain_wr_addr", x_wr_addr, 0);
    endtask

    initial begin
        int hs;
        reset     = 1'b0;
        s_valid_x = 1'b1;
        m_ready_y = 1'b1;
        #2;
        $display("[TB] reset asserted, checking outputs before any clock edge");
        check_all_zero("rst");

        @(negedge clk);
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        reset     = 1'b1;
        #1;
        check_output("rel_ready", s_ready_x, 1);
        check_output("rel_busy", busy, 0);

        $display("[TB] vector 1: back-to-back load, compute, free-running drain");
        load_fast();
        compute_check();
        drain_fast();

        $display("[TB] vector 2: gapped load, backpressured drain");
        hs = 0;
        for (int j = 0; j < 22; j++) begin
            logic v;
            v = (j % 3 == 0);
            apply_stimulus(v, 1'b0);
            check_output("gap_ready", s_ready_x, 1);
            check_output("gap_wr_en", x_wr_en, v);
            check_output("gap_wr_addr", x_wr_addr, hs);
            if (v) hs++;
        end
        apply_stimulus(1'b0, 1'b0);
        check_output("gap_done_ready", s_ready_x, 0);
        check_output("gap_done_busy", busy, 1);
        check_output("gap_cmp0_clr", clr_acc, 3);
        for (int c = 1; c < 16; c++) apply_stimulus(1'b0, 1'b0);
        check_output("gap_last_y_wr_en", y_wr_en, 1);
        check_output("gap_last_y_wr_addr", y_wr_addr, 4);
        drain_step(1'b1, 1'b0, 0);
        drain_step(1'b1, 1'b1, 0);
        drain_step(1'b1, 1'b0, 1);
        drain_step(1'b1, 1'b1, 1);
        drain_step(1'b1, 1'b0, 2);
        drain_step(1'b0, 1'b1, 2);
        drain_step(1'b0, 1'b1, 2);
        drain_step(1'b0, 1'b1, 2);
        drain_step(1'b1, 1'b1, 2);
        drain_step(1'b1, 1'b0, 3);
        drain_step(1'b1, 1'b1, 3);
        drain_step(1'b1, 1'b0, 4);
        drain_step(1'b1, 1'b1, 4);
        apply_stimulus(1'b0, 1'b0);
        check_output("bp_done_ready", s_ready_x, 1);
        check_output("bp_done_busy", busy, 0);

        $display("[TB] vector 3: reset at COMPUTE cycle 7");
        load_fast();
        for (int c = 1; c <= 7; c++) apply_stimulus(1'b0, 1'b0);
        check_output("mid_busy", busy, 1);
        check_output("mid_x_rd_base", x_rd_base, 4);
        check_output("mid_f_rd_addr", f_rd_addr, 2);
        check_output("mid_en_acc", en_acc, 3);
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("mid_rel_ready", s_ready_x, 1);
        check_output("mid_rel_wr_addr", x_wr_addr, 0);

        $display("[TB] vector 4: fresh vector after mid-compute reset");
        load_fast();
        compute_check();
        drain_fast();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
